// File: rtl/timer_control_if.sv
// Signal bundle between the timer sequencer and its neighbours: debounced buttons
// and countdown status coming in, preset/strobes/status going out.
interface timer_control_if;
   logic        start_p;
   logic        incr_p;
   logic        mode;
   logic        count_zero;
   logic [15:0] preset;
   logic        load;
   logic        tick;
   logic [2:0]  state;
   logic        alarm;
   logic        blink;

   modport master (
      output start_p, incr_p, mode, count_zero,
      input  preset, load, tick, state, alarm, blink
   );

   modport slave (
      input  start_p, incr_p, mode, count_zero,
      output preset, load, tick, state, alarm, blink
   );
endinterface

// File: rtl/timer_control.sv
// Countdown timer sequencer: BCD MM:SS preset editing, load strobe, 1 Hz tick
// generation with pause/resume, and a timed blinking alarm at 00:00.
//
// state   | meaning
// IDLE    | waiting; mode enters SET, start_p launches RUN
// SET     | incr_p edits preset; leaving emits load
// RUN     | prescaler counting, tick on each wrap
// PAUSE   | prescaler frozen, phase kept for resume
// EXPIRED | alarm on, blink toggles per wrap, auto-return after ALARM_TICKS
module timer_control #(
   parameter int unsigned TICK_DIV    = 50000000,
   parameter int unsigned ALARM_TICKS = 10
) (
   input  logic           clk,
   input  logic           reset,
   timer_control_if.slave bus
);

   localparam logic [2:0] IDLE    = 3'b000;
   localparam logic [2:0] SET     = 3'b001;
   localparam logic [2:0] RUN     = 3'b010;
   localparam logic [2:0] PAUSE   = 3'b011;
   localparam logic [2:0] EXPIRED = 3'b100;

   localparam int PW = $clog2(TICK_DIV);
   localparam int WW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WW-1:0] WRAP_LAST  = WW'(ALARM_TICKS - 1);

   logic [2:0]    state_q,  state_d;
   logic [15:0]   preset_q, preset_d;
   logic [PW-1:0] presc_q,  presc_d;
   logic [WW-1:0] wrap_q,   wrap_d;
   logic          load_q,   load_d;
   logic          tick_q,   tick_d;
   logic          alarm_q,  alarm_d;
   logic          blink_q,  blink_d;
   logic          presc_wrap;

   // Ripple-carry BCD increment of MM:SS; 59:59 rolls over to 00:00.
   function automatic logic [15:0] bcd_incr(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd9) begin
         r[3:0] = v[3:0] + 4'd1;
      end else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) begin
            r[7:4] = v[7:4] + 4'd1;
         end else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) begin
               r[11:8] = v[11:8] + 4'd1;
            end else begin
               r[11:8]  = 4'd0;
               r[15:12] = (v[15:12] != 4'd5) ? v[15:12] + 4'd1 : 4'd0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      state_d    = state_q;
      preset_d   = preset_q;
      presc_d    = presc_q;
      wrap_d     = wrap_q;
      blink_d    = blink_q;
      load_d     = 1'b0;
      tick_d     = 1'b0;
      presc_wrap = (presc_q == PRESC_LAST);

      case (state_q)
         IDLE: begin
            presc_d = '0;
            wrap_d  = '0;
            blink_d = 1'b0;
            if (bus.mode) begin
               state_d = SET;
            end else if (bus.start_p && !bus.count_zero) begin
               state_d = RUN;
            end
         end
         SET: begin
            presc_d = '0;
            if (bus.incr_p) begin
               preset_d = bcd_incr(preset_q);
            end
            if (!bus.mode) begin
               state_d = IDLE;
               load_d  = 1'b1;
            end
         end
         RUN: begin
            // count_zero wins over a coincident wrap so no tick follows 00:00.
            if (bus.count_zero) begin
               state_d = EXPIRED;
               presc_d = '0;
               wrap_d  = '0;
               blink_d = 1'b0;
            end else if (bus.start_p) begin
               state_d = PAUSE;
            end else if (presc_wrap) begin
               presc_d = '0;
               tick_d  = 1'b1;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         PAUSE: begin
            if (bus.start_p) begin
               state_d = RUN;
            end else if (bus.mode) begin
               state_d = SET;
               presc_d = '0;
            end
         end
         EXPIRED: begin
            if (bus.start_p || bus.mode) begin
               state_d = bus.start_p ? IDLE : SET;
               presc_d = '0;
               wrap_d  = '0;
               blink_d = 1'b0;
            end else if (presc_wrap) begin
               presc_d = '0;
               if (wrap_q == WRAP_LAST) begin
                  state_d = IDLE;
                  wrap_d  = '0;
                  blink_d = 1'b0;
               end else begin
                  wrap_d  = wrap_q + 1'b1;
                  blink_d = !blink_q;
               end
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            presc_d = '0;
            wrap_d  = '0;
            blink_d = 1'b0;
         end
      endcase

      alarm_d = (state_d == EXPIRED);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         preset_q <= '0;
         presc_q  <= '0;
         wrap_q   <= '0;
         load_q   <= 1'b0;
         tick_q   <= 1'b0;
         alarm_q  <= 1'b0;
         blink_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         preset_q <= preset_d;
         presc_q  <= presc_d;
         wrap_q   <= wrap_d;
         load_q   <= load_d;
         tick_q   <= tick_d;
         alarm_q  <= alarm_d;
         blink_q  <= blink_d;
      end
   end

   assign bus.state  = state_q;
   assign bus.preset = preset_q;
   assign bus.load   = load_q;
   assign bus.tick   = tick_q;
   assign bus.alarm  = alarm_q;
   assign bus.blink  = blink_q;

endmodule

// File: tb/tb_timer_control.sv
// Bench for timer_control: vector table, directed multi-cycle sequences and a
// randomized run, all checked each cycle against a seconds/cycle-count model.
module tb_timer_control;

   localparam int TICK_DIV    = 8;
   localparam int ALARM_TICKS = 3;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SET   = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_EXP   = 3'd4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   timer_control_if bus();

   timer_control #(.TICK_DIV(TICK_DIV), .ALARM_TICKS(ALARM_TICKS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: preset held as whole seconds, run phase and alarm time as cycle counts.
   logic [2:0] m_state;
   int         m_secs, m_phase, m_exp;
   logic       m_load, m_tick;

   typedef struct {
      logic start, incr, mode, cz;
      logic [2:0]  st;
      logic [15:0] pre;
      logic ld, tk;
   } vec_t;
   vec_t tbl[13];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [15:0] to_bcd(input int secs);
      int mm, ss;
      mm = secs / 60;
      ss = secs % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic model_edge();
      m_load = 1'b0;
      m_tick = 1'b0;
      case (m_state)
         S_IDLE:
            if (bus.mode) m_state = S_SET;
            else if (bus.start_p && !bus.count_zero) begin
               m_state = S_RUN;
               m_phase = 0;
            end
         S_SET: begin
            if (bus.incr_p) m_secs = (m_secs + 1) % 3600;
            if (!bus.mode) begin
               m_state = S_IDLE;
               m_load  = 1'b1;
            end
         end
         S_RUN:
            if (bus.count_zero) begin
               m_state = S_EXP;
               m_exp   = 0;
            end else if (bus.start_p) m_state = S_PAUSE;
            else begin
               m_phase++;
               if (m_phase == TICK_DIV) begin
                  m_phase = 0;
                  m_tick  = 1'b1;
               end
            end
         S_PAUSE:
            if (bus.start_p) m_state = S_RUN;
            else if (bus.mode) m_state = S_SET;
         S_EXP:
            if (bus.start_p) m_state = S_IDLE;
            else if (bus.mode) m_state = S_SET;
            else begin
               m_exp++;
               if (m_exp == ALARM_TICKS * TICK_DIV) m_state = S_IDLE;
            end
         default: m_state = S_IDLE;
      endcase
   endtask

   task automatic step();
      logic m_alarm, m_blink;
      @(posedge clk);
      model_edge();
      #1;
      m_alarm = (m_state == S_EXP);
      m_blink = m_alarm && (((m_exp / TICK_DIV) % 2) == 1);
      chk("model_outputs",
          {9'd0, bus.state, bus.preset, bus.load, bus.tick, bus.alarm, bus.blink},
          {9'd0, m_state, to_bcd(m_secs), m_load, m_tick, m_alarm, m_blink});
   endtask

   task automatic set_in(input logic s, input logic i, input logic m, input logic c);
      bus.start_p = s; bus.incr_p = i; bus.mode = m; bus.count_zero = c;
   endtask

   // Asserts reset between clock edges and checks the outputs clear without an edge.
   task automatic do_reset();
      set_in(0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("async_reset_outputs",
          {9'd0, bus.state, bus.preset, bus.load, bus.tick, bus.alarm, bus.blink}, 32'd0);
      m_state = S_IDLE; m_secs = 0; m_phase = 0; m_exp = 0; m_load = 0; m_tick = 0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      set_in(0, 0, 0, 0);
      #2;
      do_reset();

      // Set/idle/run/pause decisions, one row per cycle.
      tbl[0]  = '{0, 0, 1, 0, S_SET,   16'h0000, 0, 0};
      tbl[1]  = '{0, 1, 1, 0, S_SET,   16'h0001, 0, 0};
      tbl[2]  = '{0, 1, 1, 0, S_SET,   16'h0002, 0, 0};
      tbl[3]  = '{0, 1, 0, 0, S_IDLE,  16'h0003, 1, 0};
      tbl[4]  = '{0, 0, 0, 0, S_IDLE,  16'h0003, 0, 0};
      tbl[5]  = '{1, 0, 0, 1, S_IDLE,  16'h0003, 0, 0};
      tbl[6]  = '{0, 1, 0, 0, S_IDLE,  16'h0003, 0, 0};
      tbl[7]  = '{1, 0, 0, 0, S_RUN,   16'h0003, 0, 0};
      tbl[8]  = '{0, 0, 1, 0, S_RUN,   16'h0003, 0, 0};
      tbl[9]  = '{1, 0, 0, 0, S_PAUSE, 16'h0003, 0, 0};
      tbl[10] = '{0, 0, 1, 0, S_SET,   16'h0003, 0, 0};
      tbl[11] = '{1, 0, 1, 0, S_SET,   16'h0003, 0, 0};
      tbl[12] = '{0, 0, 0, 0, S_IDLE,  16'h0003, 1, 0};
      for (int i = 0; i < 13; i++) begin
         set_in(tbl[i].start, tbl[i].incr, tbl[i].mode, tbl[i].cz);
         step();
         chk($sformatf("tbl%0d_state", i),  32'(bus.state),  32'(tbl[i].st));
         chk($sformatf("tbl%0d_preset", i), 32'(bus.preset), 32'(tbl[i].pre));
         chk($sformatf("tbl%0d_load", i),   32'(bus.load),   32'(tbl[i].ld));
         chk($sformatf("tbl%0d_tick", i),   32'(bus.tick),   32'(tbl[i].tk));
      end

      // Twelve increments then leave SET.
      do_reset();
      set_in(0, 0, 1, 0); step();
      for (int i = 0; i < 12; i++) begin set_in(0, 1, 1, 0); step(); end
      set_in(0, 0, 0, 0); step();
      chk("set12_preset", 32'(bus.preset), 32'h0012);
      chk("set12_load",   32'(bus.load),   32'd1);
      chk("set12_state",  32'(bus.state),  32'(S_IDLE));
      step();
      chk("set12_load_once", 32'(bus.load), 32'd0);

      // BCD carries and full wrap.
      do_reset();
      set_in(0, 0, 1, 0); step();
      set_in(0, 1, 1, 0);
      for (int i = 0; i < 599; i++) step();
      chk("bcd_0959", 32'(bus.preset), 32'h0959);
      step();
      chk("bcd_1000", 32'(bus.preset), 32'h1000);
      for (int i = 0; i < 2999; i++) step();
      chk("bcd_5959", 32'(bus.preset), 32'h5959);
      step();
      chk("bcd_wrap", 32'(bus.preset), 32'h0000);
      for (int i = 0; i < 9; i++) step();
      chk("bcd_0009", 32'(bus.preset), 32'h0009);
      set_in(0, 1, 0, 0); step();
      chk("incr_on_exit_load",   32'(bus.load),   32'd1);
      chk("incr_on_exit_preset", 32'(bus.preset), 32'h0010);
      set_in(0, 0, 0, 0);

      // Run, tick cadence, pause/resume phase.
      do_reset();
      set_in(1, 0, 0, 0); step();
      set_in(0, 0, 0, 0);
      for (int k = 1; k <= 24; k++) begin
         step();
         chk($sformatf("run_tick_k%0d", k), 32'(bus.tick), 32'((k % 8) == 0));
      end
      for (int k = 0; k < 3; k++) step();
      set_in(1, 0, 0, 0); step();
      set_in(0, 0, 0, 0);
      chk("pause_state", 32'(bus.state), 32'(S_PAUSE));
      begin
         int ticks_seen = 0;
         for (int k = 0; k < 20; k++) begin step(); if (bus.tick) ticks_seen++; end
         chk("pause_no_tick", 32'(ticks_seen), 32'd0);
      end
      set_in(1, 0, 0, 0); step();
      set_in(0, 0, 0, 0);
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("resume_tick_k%0d", k), 32'(bus.tick), 32'(k == 5));
      end

      // Expiry and automatic return.
      set_in(0, 0, 0, 1); step();
      chk("exp_state", 32'(bus.state), 32'(S_EXP));
      chk("exp_alarm", 32'(bus.alarm), 32'd1);
      for (int k = 1; k <= 24; k++) begin
         step();
         chk($sformatf("exp_blink_k%0d", k), 32'(bus.blink), 32'(k >= 8 && k < 16));
         chk($sformatf("exp_state_k%0d", k), 32'(bus.state), 32'(k == 24 ? S_IDLE : S_EXP));
         chk($sformatf("exp_tick_k%0d", k),  32'(bus.tick),  32'd0);
      end
      chk("exp_done_alarm", 32'(bus.alarm), 32'd0);

      // Expiry acknowledged by start_p.
      set_in(1, 0, 0, 0); step();
      set_in(0, 0, 0, 0); step(); step();
      set_in(0, 0, 0, 1); step();
      chk("exp2_state", 32'(bus.state), 32'(S_EXP));
      for (int k = 1; k <= 4; k++) step();
      set_in(1, 0, 1, 1); step();
      chk("ack_state", 32'(bus.state), 32'(S_IDLE));
      chk("ack_alarm", 32'(bus.alarm), 32'd0);
      chk("ack_blink", 32'(bus.blink), 32'd0);
      set_in(0, 0, 0, 0);

      // Asynchronous reset while a tick is showing.
      do_reset();
      set_in(0, 0, 1, 0); step();
      for (int k = 0; k < 3; k++) begin set_in(0, 1, 1, 0); step(); end
      set_in(0, 0, 0, 0); step();
      set_in(1, 0, 0, 0); step();
      set_in(0, 0, 0, 0);
      begin
         bit seen = 0;
         for (int k = 0; k < 20 && !seen; k++) begin step(); seen = bus.tick; end
         chk("midrun_tick_seen", 32'(seen), 32'd1);
      end
      #2;
      reset = 1'b1;
      #1;
      chk("midrun_reset_tick",   32'(bus.tick),   32'd0);
      chk("midrun_reset_state",  32'(bus.state),  32'(S_IDLE));
      chk("midrun_reset_preset", 32'(bus.preset), 32'h0000);
      m_state = S_IDLE; m_secs = 0; m_phase = 0; m_exp = 0; m_load = 0; m_tick = 0;
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("post_reset_load_tick", {30'd0, bus.load, bus.tick}, 32'd0);

      // Randomized traffic against the model.
      begin
         logic cz = 1'b0;
         logic md = 1'b0;
         for (int k = 0; k < 3000; k++) begin
            if (!cz && $urandom_range(0, 29) == 0) cz = 1'b1;
            else if (cz && $urandom_range(0, 3) == 0) cz = 1'b0;
            if ($urandom_range(0, 11) == 0) md = !md;
            set_in($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, md, cz);
            step();
         end
      end
      set_in(0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
